// File: rtl/sa_share.sv
// Shared definitions for the systolic-array control path.
// Holds the instruction word layout, the opcode map understood by the
// control unit and the state encoding of the instruction issuer.
// No ports: package only.
package sa_share;

  localparam int ISA_BITS     = 16;
  localparam int OPERAND_BITS = 8;
  localparam int OPCODE_BITS  = ISA_BITS - OPERAND_BITS;

  localparam logic [OPCODE_BITS-1:0] OP_IDLE         = 8'h00;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = 8'h01;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = 8'h02;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = 8'h03;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = 8'h04;
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = 8'h05;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_RESULT = 8'h06;
  localparam logic [OPCODE_BITS-1:0] OP_HALT         = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_ISSUE   = 3'd3,
    S_RELEASE = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } issuer_state_e;

endpackage

// File: rtl/inst_issuer.sv
// Instruction issuer: fetches a program from instruction memory and hands
// each word to the control unit over the instruction/flag handshake.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 host start pulse (honoured only when idle)
//   base_addr, prog_len   program location and length, latched on start
//   imem_en, imem_addr    memory read request (data one cycle later)
//   imem_dout             memory read data
//   instruction           word driven to the control unit (IDLE when not issuing)
//   flag                  completion flag from the control unit
//   busy, done, pc        status to the host
//   timeout_err           sticky watchdog error
//
// Build option: define INST_ISSUER_TIMEOUT_EN to enable the watchdog that
// abandons an instruction the control unit never completes.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FETCH   | read request for word base+pc
// S_WAIT    | memory data arrives; decode HALT / NOP
// S_ISSUE   | word driven, waiting for flag
// S_RELEASE | IDLE driven, waiting for flag to drop
// S_NEXT    | advance pc or finish
// S_DONE    | one-cycle done pulse
module inst_issuer
  import sa_share::*;
#(
  parameter int ISA_BITS       = sa_share::ISA_BITS,
  parameter int IMEM_ADDR_BITS = 8,
  parameter int LEN_BITS       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [IMEM_ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]       prog_len,
  output logic                      imem_en,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [ISA_BITS-1:0]       imem_dout,
  output logic [ISA_BITS-1:0]       instruction,
  input  logic                      flag,
  output logic                      busy,
  output logic                      done,
  output logic [LEN_BITS-1:0]       pc,
  output logic                      timeout_err
);

  localparam logic [ISA_BITS-1:0] INST_IDLE =
    {OP_IDLE, {(ISA_BITS-OPCODE_BITS){1'b0}}};

  issuer_state_e             state_q, state_d;
  logic [IMEM_ADDR_BITS-1:0] base_q, base_d;
  logic [LEN_BITS-1:0]       len_q, len_d;
  logic [LEN_BITS-1:0]       pc_q, pc_d;
  logic [ISA_BITS-1:0]       word_q, word_d;
  logic                      done_q, done_d;
  logic [OPCODE_BITS-1:0]    fetched_op;
  logic [LEN_BITS-1:0]       pc_inc;

`ifdef INST_ISSUER_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_BITS-1:0] WD_LOAD = WD_BITS'(TIMEOUT_CYCLES - 1);

  // Down-counter loaded on the way into S_ISSUE; terminal count 0 marks the
  // last allowed cycle in S_ISSUE.
  logic [WD_BITS-1:0] wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  assign fetched_op = imem_dout[ISA_BITS-1 -: OPCODE_BITS];
  assign pc_inc     = pc_q + LEN_BITS'(1);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    pc_d      = pc_q;
    word_d    = word_q;
    done_d    = 1'b0;
    imem_en   = 1'b0;
    imem_addr = '0;
`ifdef INST_ISSUER_TIMEOUT_EN
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            base_d  = base_addr;
            len_d   = prog_len;
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        imem_en   = 1'b1;
        imem_addr = base_q + IMEM_ADDR_BITS'(pc_q);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        word_d = imem_dout;
`ifdef INST_ISSUER_TIMEOUT_EN
        wd_d = WD_LOAD;
`endif
        if (fetched_op == OP_HALT)      state_d = S_DONE;
        else if (fetched_op == OP_IDLE) state_d = S_NEXT;
        else                            state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (flag) begin
          state_d = S_RELEASE;
        end
`ifdef INST_ISSUER_TIMEOUT_EN
        else if (wd_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          wd_d = wd_q - WD_BITS'(1);
        end
`endif
      end
      S_RELEASE: begin
        // Always spend at least one cycle here so a flag still high from the
        // previous word cannot complete the next one.
        if (!flag) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (pc_inc == len_q) begin
          state_d = S_DONE;
        end else begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // done is registered so it is high for exactly the S_DONE cycle.
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      pc_q    <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
`ifdef INST_ISSUER_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      done_q  <= done_d;
`ifdef INST_ISSUER_TIMEOUT_EN
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign instruction = (state_q == S_ISSUE) ? word_q : INST_IDLE;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = done_q;
  assign pc          = pc_q;

`ifdef INST_ISSUER_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_issuer.sv
module tb_inst_issuer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  prog_len;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_dout;
  logic [15:0] instruction;
  logic        flag;
  logic        busy;
  logic        done;
  logic [7:0]  pc;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];
  bit          read_hit [0:255];
  int          rd_cnt;
  logic [7:0]  last_rd;
  int          done_cnt;
  logic [15:0] issued [$];
  logic [15:0] prev_instr;

  inst_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .prog_len    (prog_len),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .instruction (instruction),
    .flag        (flag),
    .busy        (busy),
    .done        (done),
    .pc          (pc),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory with a read log.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_dout <= mem[imem_addr];
      read_hit[imem_addr] <= 1'b1;
      rd_cnt <= rd_cnt + 1;
      last_rd <= imem_addr;
    end
  end

  // Record every non-IDLE word presented to the control unit and done pulses.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (instruction !== prev_instr) begin
      if (instruction !== 16'h0000) issued.push_back(instruction);
      prev_instr = instruction;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic clear_logs();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0000;
      read_hit[i] = 1'b0;
    end
    rd_cnt = 0;
    last_rd = 8'h00;
    done_cnt = 0;
    issued.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    flag = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic kick(input logic [7:0] b, input logic [7:0] l);
    base_addr = b;
    prog_len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_issue(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instruction !== 16'h0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Control-unit model: raise flag after 'delay' cycles of a non-IDLE word,
  // drop it once the issuer returns to IDLE. Returns when done is seen.
  task automatic drive_cu(input int delay, input int budget, output bit ok);
    int  cnt;
    bit  raised;
    cnt = 0;
    raised = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (!raised) begin
        if (instruction !== 16'h0000) begin
          cnt++;
          if (cnt >= delay) begin
            flag = 1'b1;
            raised = 1'b1;
            cnt = 0;
          end
        end
      end else if (instruction === 16'h0000) begin
        flag = 1'b0;
        raised = 1'b0;
      end
    end
    flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    base_addr = 8'h55;
    prog_len = 8'h03;
    flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instruction got=%h exp=%h", instruction, 16'h0000); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en got=%b exp=0", imem_en); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_imem_addr got=%h exp=00", imem_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] got;
    do_reset();
    mem[8'h10] = 16'h0105;
    mem[8'h11] = 16'h0220;
    kick(8'h10, 8'd2);
    checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h10) begin errors++; $display("FAIL basic_fetch0 got en=%b addr=%h exp en=1 addr=10", imem_en, imem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    repeat (2) @(negedge clk);
    checks++; if (instruction !== 16'h0105) begin errors++; $display("FAIL basic_first_issue_latency got=%h exp=0105", instruction); end
    drive_cu(3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    checks++; if (issued.size() !== 2) begin errors++; $display("FAIL basic_issue_count got=%0d exp=2", issued.size()); end
    got = (issued.size() > 0) ? issued[0] : 16'hxxxx;
    checks++; if (got !== 16'h0105) begin errors++; $display("FAIL basic_word0 got=%h exp=0105", got); end
    got = (issued.size() > 1) ? issued[1] : 16'hxxxx;
    checks++; if (got !== 16'h0220) begin errors++; $display("FAIL basic_word1 got=%h exp=0220", got); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL basic_pc got=%h exp=01", pc); end
    checks++; if (busy !== 1'b0 || instruction !== 16'h0000) begin errors++; $display("FAIL basic_idle_after got busy=%b instr=%h exp busy=0 instr=0000", busy, instruction); end
    checks++; if (rd_cnt !== 2) begin errors++; $display("FAIL basic_reads got=%0d exp=2", rd_cnt); end
  endtask

  task automatic test_zero_length();
    do_reset();
    kick(8'h40, 8'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%b exp=0", done); end
    repeat (4) @(negedge clk);
    checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL zero_no_fetch got=%0d exp=0", rd_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_halt_nop();
    bit ok;
    do_reset();
    mem[0] = 16'h0000;
    mem[1] = 16'hFF00;
    mem[2] = 16'h0301;
    kick(8'h00, 8'd3);
    // FETCH0, WAIT, NEXT, FETCH1, WAIT, DONE: done visible at the fifth negedge.
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_early got=%b exp=0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done_time got=%b exp=1", done); end
    wait_done(1, ok);
    repeat (3) @(negedge clk);
    checks++; if (issued.size() !== 0) begin errors++; $display("FAIL halt_nothing_issued got=%0d exp=0", issued.size()); end
    checks++; if (read_hit[2] !== 1'b0) begin errors++; $display("FAIL halt_addr2_read got=%b exp=0", read_hit[2]); end
    checks++; if (read_hit[1] !== 1'b1 || rd_cnt !== 2) begin errors++; $display("FAIL halt_reads got hit1=%b cnt=%0d exp hit1=1 cnt=2", read_hit[1], rd_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL halt_done_count got=%0d exp=1", done_cnt); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL halt_pc got=%h exp=01", pc); end
  endtask

  task automatic test_stale_wrap();
    bit ok;
    do_reset();
    mem[8'hFF] = 16'h0405;
    mem[8'h00] = 16'h0506;
    mem[8'h80] = 16'h0606;
    kick(8'hFF, 8'd2);
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL stale_fetch0_addr got=%h exp=FF", imem_addr); end
    wait_issue(10, ok);
    checks++; if (!ok || instruction !== 16'h0405) begin errors++; $display("FAIL stale_word0 got=%h exp=0405", instruction); end
    @(negedge clk);
    flag = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL stale_release_idle got=%h exp=0000", instruction); end
    start = 1'b1;
    base_addr = 8'h80;
    prog_len = 8'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (instruction !== 16'h0000 || rd_cnt !== 1 || busy !== 1'b1) begin errors++; $display("FAIL stale_hold_release cyc=%0d got instr=%h reads=%0d busy=%b exp instr=0000 reads=1 busy=1", i, instruction, rd_cnt, busy); end
    end
    flag = 1'b0;
    start = 1'b0;
    wait_issue(10, ok);
    checks++; if (!ok || instruction !== 16'h0506) begin errors++; $display("FAIL stale_word1 got=%h exp=0506", instruction); end
    checks++; if (last_rd !== 8'h00) begin errors++; $display("FAIL stale_wrap_addr got=%h exp=00", last_rd); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL stale_pc got=%h exp=01", pc); end
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    wait_done(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stale_done got=no_done exp=done"); end
    checks++; if (read_hit[8'h80] !== 1'b0 || rd_cnt !== 2) begin errors++; $display("FAIL stale_start_ignored got hit80=%b reads=%0d exp hit80=0 reads=2", read_hit[8'h80], rd_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    mem[8'h20] = 16'h0601;
    mem[8'h21] = 16'h0602;
    kick(8'h20, 8'd2);
    wait_issue(10, ok);
    checks++; if (!ok || instruction !== 16'h0601) begin errors++; $display("FAIL rstmid_word0 got=%h exp=0601", instruction); end
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    wait_issue(10, ok);
    checks++; if (!ok || instruction !== 16'h0602 || pc !== 8'h01) begin errors++; $display("FAIL rstmid_word1 got instr=%h pc=%h exp instr=0602 pc=01", instruction, pc); end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL rstmid_instr got=%h exp=0000", instruction); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL rstmid_pc got=%h exp=00", pc); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rstmid_imem_en got=%b exp=0", imem_en); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_start_during_reset got busy=%b done=%b exp busy=0 done=0", busy, done); end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_after_release got busy=%b exp=0", busy); end
  endtask

`ifdef INST_ISSUER_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok;
    int cnt;
    do_reset();
    mem[8'h30] = 16'h0507;
    kick(8'h30, 8'd1);
    wait_issue(10, ok);
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (instruction === 16'h0000) break;
      cnt++;
    end
    checks++; if (cnt !== 64) begin errors++; $display("FAIL wd_issue_cycles got=%0d exp=64", cnt); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_err_set got=%b exp=1", timeout_err); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wd_done got=%b exp=1", done); end
    repeat (5) @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_sticky got err=%b busy=%b exp err=1 busy=0", timeout_err, busy); end
    do_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_cleared got=%b exp=0", timeout_err); end
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    do_reset();
    mem[8'h30] = 16'h0507;
    kick(8'h30, 8'd1);
    wait_issue(10, ok);
    repeat (80) @(negedge clk);
    checks++; if (instruction !== 16'h0507) begin errors++; $display("FAIL nowd_held got=%h exp=0507", instruction); end
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL nowd_state got err=%b busy=%b exp err=0 busy=1", timeout_err, busy); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL nowd_no_done got=%0d exp=0", done_cnt); end
    flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    wait_done(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nowd_finish got=no_done exp=done"); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 8'h00;
    prog_len = 8'h00;
    flag = 1'b0;
    imem_dout = 16'h0000;
    prev_instr = 16'h0000;
    clear_logs();
    test_reset();
    test_basic();
    test_zero_length();
    test_halt_nop();
    test_stale_wrap();
    test_reset_mid();
`ifdef INST_ISSUER_TIMEOUT_EN
    test_watchdog();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
